// File: rtl/fpnew_issue_rob.sv
// fpnew_issue_rob: tags client requests for the FPU, collects tagged results
// in a reorder ring and returns them to the client strictly in request order.
// Ports:
//   clk_i/rst_ni          clock, async active-low reset
//   req_*                 client request handshake and fields
//   fpu_in_*/fpu_*_o      FPU input handshake, forwarded fields, tag, flush
//   fpu_out_*/fpu_*_i     FPU result handshake, result, status, tag
//   rsp_*                 in-order client response
//   flush_i/clr_status_i  abort outstanding ops / clear accrued status
//   accrued_status_o      sticky OR of retired statuses
//   err_o                 sticky: result for a tag that was not outstanding
//   busy_o                any entry outstanding
module fpnew_issue_rob #(
  parameter int unsigned FLEN      = 16,
  parameter int unsigned TAG_WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [2:0][FLEN-1:0]     req_operands_i,
  input  logic [3:0]               req_op_i,
  input  logic                     req_op_mod_i,
  input  logic [2:0]               req_rnd_mode_i,
  output logic                     fpu_in_valid_o,
  input  logic                     fpu_in_ready_i,
  output logic [2:0][FLEN-1:0]     fpu_operands_o,
  output logic [3:0]               fpu_op_o,
  output logic                     fpu_op_mod_o,
  output logic [2:0]               fpu_rnd_mode_o,
  output logic [TAG_WIDTH-1:0]     fpu_tag_o,
  output logic                     fpu_flush_o,
  input  logic                     fpu_out_valid_i,
  output logic                     fpu_out_ready_o,
  input  logic [FLEN-1:0]          fpu_result_i,
  input  logic [4:0]               fpu_status_i,
  input  logic [TAG_WIDTH-1:0]     fpu_tag_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [FLEN-1:0]          rsp_result_o,
  output logic [4:0]               rsp_status_o,
  input  logic                     flush_i,
  input  logic                     clr_status_i,
  output logic [4:0]               accrued_status_o,
  output logic                     err_o,
  output logic                     busy_o
);

  localparam int unsigned D = 1 << TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] L_D = (TAG_WIDTH+1)'(D);

  logic [TAG_WIDTH-1:0] r_ip;
  logic [TAG_WIDTH-1:0] r_hp;
  logic [TAG_WIDTH:0]   r_count;
  logic [D-1:0]         r_out;
  logic [D-1:0]         r_done;
  logic [FLEN-1:0]      r_res [D];
  logic [4:0]           r_stat [D];
  logic [4:0]           r_acc;
  logic                 r_err;

  logic w_full;
  logic w_iss;
  logic w_res;
  logic w_wr;
  logic w_ret;

  assign w_full = (r_count == L_D);

  assign fpu_in_valid_o = req_valid_i & ~w_full & ~flush_i;
  assign req_ready_o    = fpu_in_ready_i & ~w_full & ~flush_i;
  assign w_iss          = req_valid_i & req_ready_o;

  assign fpu_operands_o = req_operands_i;
  assign fpu_op_o       = req_op_i;
  assign fpu_op_mod_o   = req_op_mod_i;
  assign fpu_rnd_mode_o = req_rnd_mode_i;
  assign fpu_tag_o      = r_ip;
  assign fpu_flush_o    = flush_i;

  // Every issued op owns a slot, so results are never back-pressured.
  assign fpu_out_ready_o = ~flush_i;
  assign w_res = fpu_out_valid_i & ~flush_i;
  assign w_wr  = w_res & r_out[fpu_tag_i] & ~r_done[fpu_tag_i];

  assign rsp_valid_o  = r_done[r_hp] & ~flush_i;
  assign rsp_result_o = r_res[r_hp];
  assign rsp_status_o = r_stat[r_hp];
  assign w_ret        = rsp_valid_o & rsp_ready_i;

  assign accrued_status_o = r_acc;
  assign err_o            = r_err;
  assign busy_o           = (r_count != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ip    <= '0;
      r_hp    <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_done  <= '0;
      for (int i = 0; i < D; i++) begin
        r_res[i]  <= '0;
        r_stat[i] <= '0;
      end
    end else if (flush_i) begin
      r_ip    <= '0;
      r_hp    <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_done  <= '0;
    end else begin
      // Issue, write and retire always target distinct slots.
      if (w_iss) begin
        r_out[r_ip]  <= 1'b1;
        r_done[r_ip] <= 1'b0;
        r_ip         <= r_ip + 1'b1;
      end
      if (w_wr) begin
        r_done[fpu_tag_i] <= 1'b1;
        r_res[fpu_tag_i]  <= fpu_result_i;
        r_stat[fpu_tag_i] <= fpu_status_i;
      end
      if (w_ret) begin
        r_out[r_hp]  <= 1'b0;
        r_done[r_hp] <= 1'b0;
        r_hp         <= r_hp + 1'b1;
      end
      unique case ({w_iss, w_ret})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Accrued status and error survive a flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_ret) begin
        r_acc <= clr_status_i ? rsp_status_o : (r_acc | rsp_status_o);
      end else if (clr_status_i) begin
        r_acc <= '0;
      end
      if (w_res && !w_wr) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpnew_issue_rob.sv
// tb_fpnew_issue_rob: table vectors for the issue handshake under reset,
// plus scoreboarded sequences for ordering, full, flush, status and reset.
module tb_fpnew_issue_rob;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              req_valid;
  logic              req_ready_o;
  logic [2:0][15:0]  req_operands;
  logic [3:0]        req_op;
  logic              req_op_mod;
  logic [2:0]        req_rnd;
  logic              fpu_in_valid_o;
  logic              fpu_in_ready;
  logic [2:0][15:0]  fpu_operands_o;
  logic [3:0]        fpu_op_o;
  logic              fpu_op_mod_o;
  logic [2:0]        fpu_rnd_mode_o;
  logic [1:0]        fpu_tag_o;
  logic              fpu_flush_o;
  logic              fpu_out_valid;
  logic              fpu_out_ready_o;
  logic [15:0]       fpu_result;
  logic [4:0]        fpu_status;
  logic [1:0]        fpu_tag;
  logic              rsp_valid_o;
  logic              rsp_ready;
  logic [15:0]       rsp_result_o;
  logic [4:0]        rsp_status_o;
  logic              flush;
  logic              clr_status;
  logic [4:0]        acc_o;
  logic              err_o;
  logic              busy_o;

  fpnew_issue_rob #(.FLEN(16), .TAG_WIDTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_operands_i(req_operands), .req_op_i(req_op),
    .req_op_mod_i(req_op_mod), .req_rnd_mode_i(req_rnd),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o),
    .fpu_op_mod_o(fpu_op_mod_o), .fpu_rnd_mode_o(fpu_rnd_mode_o),
    .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status),
    .fpu_tag_i(fpu_tag),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
    .flush_i(flush), .clr_status_i(clr_status),
    .accrued_status_o(acc_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rv;
    logic ir;
    logic fl;
    logic ev;
    logic er;
    logic eor;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  st;
  } exp_t;

  vec_t tbl [8];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string n,
                              input logic [63:0] a,
                              input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endfunction

  // Scoreboard: a response fires at the next edge when valid&ready now.
  always @(negedge clk) begin
    if (rst_ni && rsp_valid_o && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%0h required=none",
                 rsp_result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result", rsp_result_o, e.res);
        chk("rsp_status", rsp_status_o, e.st);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [47:0] ops, input int tag,
                       input logic [15:0] res, input logic [4:0] st);
    exp_t e;
    req_valid = 1'b1;
    req_operands = ops;
    req_op = 4'h3;
    req_rnd = 3'h2;
    #1;
    chk("iss_valid", fpu_in_valid_o, 1);
    chk("iss_ready", req_ready_o, 1);
    chk("iss_tag", fpu_tag_o, tag);
    chk("iss_ops", fpu_operands_o, ops);
    chk("iss_op", {fpu_op_o, fpu_rnd_mode_o}, {4'h3, 3'h2});
    e.res = res;
    e.st = st;
    sb.push_back(e);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic ret(input int tag, input logic [15:0] res,
                     input logic [4:0] st);
    fpu_out_valid = 1'b1;
    fpu_tag = 2'(tag);
    fpu_result = res;
    fpu_status = st;
    #1;
    chk("out_ready", fpu_out_ready_o, 1);
    cyc();
    fpu_out_valid = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    int k = 0;
    while (busy_o && k < n) begin
      cyc();
      k++;
    end
    chk("idle_timeout", busy_o, 0);
    cyc();
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    cyc();
    sb.delete();
    rst_ni = 1'b1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 1};
    tbl[1] = '{0, 0, 1, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 1, 1};
    tbl[3] = '{0, 1, 1, 0, 0, 0};
    tbl[4] = '{1, 0, 0, 1, 0, 1};
    tbl[5] = '{1, 0, 1, 0, 0, 0};
    tbl[6] = '{1, 1, 0, 1, 1, 1};
    tbl[7] = '{1, 1, 1, 0, 0, 0};

    rst_ni = 1'b0;
    req_valid = 1'b0;
    req_operands = '0;
    req_op = '0;
    req_op_mod = 1'b0;
    req_rnd = '0;
    fpu_in_ready = 1'b1;
    fpu_out_valid = 1'b0;
    fpu_result = '0;
    fpu_status = '0;
    fpu_tag = '0;
    rsp_ready = 1'b1;
    flush = 1'b0;
    clr_status = 1'b0;

    // Issue handshake vectors while held in reset.
    #2;
    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].rv;
      fpu_in_ready = tbl[i].ir;
      flush = tbl[i].fl;
      #1;
      chk("tbl_in_valid", fpu_in_valid_o, tbl[i].ev);
      chk("tbl_req_ready", req_ready_o, tbl[i].er);
      chk("tbl_out_ready", fpu_out_ready_o, tbl[i].eor);
      chk("tbl_flush", fpu_flush_o, tbl[i].fl);
      chk("tbl_rsp_valid", rsp_valid_o, 0);
      chk("tbl_busy", busy_o, 0);
    end
    req_valid = 1'b0;
    fpu_in_ready = 1'b1;
    flush = 1'b0;
    chk("rst_acc", acc_o, 0);
    chk("rst_err", err_o, 0);
    do_reset();

    // Single op.
    issue({16'h0000, 16'h4000, 16'h3C00}, 0, 16'h4200, 5'h00);
    chk("single_busy", busy_o, 1);
    cyc();
    chk("single_pending", rsp_valid_o, 0);
    ret(0, 16'h4200, 5'h00);
    chk("single_rsp_valid", rsp_valid_o, 1);
    chk("single_rsp_res", rsp_result_o, 16'h4200);
    cyc();
    chk("single_busy_drop", busy_o, 0);
    wait_idle(10);

    // Out-of-order return.
    do_reset();
    issue(48'h1, 0, 16'h2222, 5'h00);
    issue(48'h2, 1, 16'h3333, 5'h00);
    issue(48'h3, 2, 16'h1111, 5'h00);
    ret(2, 16'h1111, 5'h00);
    chk("ooo_hold", rsp_valid_o, 0);
    ret(0, 16'h2222, 5'h00);
    ret(1, 16'h3333, 5'h00);
    wait_idle(10);

    // Full / back-pressure and wrap.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(48'(i + 16), i, 16'(16'hA000 + i), 5'(i));
    end
    req_valid = 1'b1;
    #1;
    chk("full_req_ready", req_ready_o, 0);
    chk("full_in_valid", fpu_in_valid_o, 0);
    chk("full_busy", busy_o, 1);
    cyc();
    req_valid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      ret(i, 16'(16'hA000 + i), 5'(i));
    end
    chk("full_rsp_waiting", rsp_valid_o, 1);
    rsp_ready = 1'b1;
    cyc();
    issue(48'h55, 0, 16'h5555, 5'h02);
    ret(0, 16'h5555, 5'h02);
    wait_idle(20);

    // Flush.
    do_reset();
    issue(48'h7, 0, 16'h0007, 5'h00);
    issue(48'h8, 1, 16'h0008, 5'h00);
    issue(48'h9, 2, 16'h0009, 5'h00);
    flush = 1'b1;
    fpu_out_valid = 1'b1;
    fpu_tag = 2'd0;
    fpu_result = 16'h0007;
    #1;
    chk("flush_out", fpu_flush_o, 1);
    chk("flush_out_ready", fpu_out_ready_o, 0);
    cyc();
    flush = 1'b0;
    fpu_out_valid = 1'b0;
    sb.delete();
    chk("flush_busy", busy_o, 0);
    chk("flush_no_err", err_o, 0);
    ret(1, 16'h0008, 5'h00);
    chk("late_err", err_o, 1);
    issue(48'hA, 0, 16'h000A, 5'h01);
    ret(0, 16'h000A, 5'h01);
    wait_idle(10);
    chk("err_sticky", err_o, 1);
    chk("acc_after_flush", acc_o, 5'h01);

    // Status accrual and clear.
    do_reset();
    rsp_ready = 1'b0;
    issue(48'h1, 0, 16'h0100, 5'h01);
    issue(48'h2, 1, 16'h0200, 5'h04);
    issue(48'h3, 2, 16'h0300, 5'h10);
    ret(0, 16'h0100, 5'h01);
    ret(1, 16'h0200, 5'h04);
    rsp_ready = 1'b1;
    cyc();
    chk("acc_first", acc_o, 5'h01);
    cyc();
    rsp_ready = 1'b0;
    chk("acc_or", acc_o, 5'h05);
    clr_status = 1'b1;
    cyc();
    clr_status = 1'b0;
    chk("acc_clr", acc_o, 5'h00);
    ret(2, 16'h0300, 5'h10);
    rsp_ready = 1'b1;
    clr_status = 1'b1;
    cyc();
    clr_status = 1'b0;
    chk("acc_clr_ret", acc_o, 5'h10);
    chk("acc_busy", busy_o, 0);

    // Async reset mid-operation.
    ret(3, 16'hDEAD, 5'h1F);
    chk("stray_err", err_o, 1);
    rsp_ready = 1'b0;
    issue(48'hB, 3, 16'h0B0B, 5'h02);
    issue(48'hC, 0, 16'h0C0C, 5'h00);
    ret(3, 16'h0B0B, 5'h02);
    chk("pre_rst_valid", rsp_valid_o, 1);
    chk("pre_rst_busy", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_acc", acc_o, 0);
    chk("arst_err", err_o, 0);
    sb.delete();
    cyc();
    rst_ni = 1'b1;
    rsp_ready = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
